// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the counter-width helper.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Ceiling log2, never less than 1 so a WIDTH=1 counter still has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: WIDTH-bit operands processed LSB first through
// one full-adder cell, result published on a one-cycle done pulse.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned    CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s;
    logic             co;

    fa_cell u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (c),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        last       = (cnt == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at R[0].
    always_comb begin
        r_next            = r >> 1;
        r_next[WIDTH-1]   = s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa       <= '0;
            sb       <= '0;
            r        <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b ^ {WIDTH{sub}};
            c   <= cin ^ sub;
            cnt <= '0;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            c   <= co;
            r   <= r_next;
            cnt <= cnt + 1'b1;
            // Outputs are a shadow copy so they hold steady through the next RUN;
            // c here is still the carry into the MSB.
            if (last) begin
                result   <= r_next;
                cout     <= co;
                overflow <= c ^ co;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=1: expectations are
// queued at stimulus time and retired on each done pulse.
module tb_serial_addsub;

    typedef struct {
        logic [7:0]  res;
        logic        co;
        logic        ovf;
        int unsigned due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic       cin8, sub8;
    logic       a1, b1, cin1, sub1;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] result8;
    logic       busy1, done1, cout1, ovf1;
    logic       result1;

    exp_t        q8[$];
    exp_t        q1[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .cin      (cin8),
        .sub      (sub8),
        .busy     (busy8),
        .done     (done8),
        .result   (result8),
        .cout     (cout8),
        .overflow (ovf8)
    );

    serial_addsub #(.WIDTH(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .a        (a1),
        .b        (b1),
        .cin      (cin1),
        .sub      (sub1),
        .busy     (busy1),
        .done     (done1),
        .result   (result1),
        .cout     (cout1),
        .overflow (ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference arithmetic: signed overflow when both addends share a sign
    // that the result does not.
    function automatic exp_t model(input int unsigned w, input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic s, input int unsigned due);
        int unsigned mask, aa, bb, full;
        exp_t e;
        mask  = (32'd1 << w) - 1;
        aa    = a & mask;
        bb    = s ? (~b & mask) : (b & mask);
        full  = aa + bb + (s ? 32'(!c) : 32'(c));
        e.res = 8'(full & mask);
        e.co  = full[w];
        e.ovf = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        check_eq("busy_done_overlap8", {31'b0, busy8 & done8}, 32'd0);
        check_eq("busy_done_overlap1", {31'b0, busy1 & done1}, 32'd0);
        if (done8) begin
            check_eq("done8_expected", {31'b0, q8.size() > 0}, 32'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check_eq("latency8", cyc, e.due);
                check_eq("result8", {24'b0, result8}, {24'b0, e.res});
                check_eq("cout8", {31'b0, cout8}, {31'b0, e.co});
                check_eq("ovf8", {31'b0, ovf8}, {31'b0, e.ovf});
            end
        end
        if (done1) begin
            check_eq("done1_expected", {31'b0, q1.size() > 0}, 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_eq("latency1", cyc, e.due);
                check_eq("result1", {31'b0, result1}, {31'b0, e.res[0]});
                check_eq("cout1", {31'b0, cout1}, {31'b0, e.co});
                check_eq("ovf1", {31'b0, ovf1}, {31'b0, e.ovf});
            end
        end
    end

    // One operation on the 8-bit unit; operands are scrambled once accepted.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        @(posedge clk); #1;
        a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
        q8.push_back(model(8, a, b, c, s, cyc + 9));
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        repeat (9) @(posedge clk);
    endtask

    task automatic check_outputs_clear8(input string tag);
        check_eq({tag, "_busy"}, {31'b0, busy8}, 32'd0);
        check_eq({tag, "_done"}, {31'b0, done8}, 32'd0);
        check_eq({tag, "_result"}, {24'b0, result8}, 32'd0);
        check_eq({tag, "_cout"}, {31'b0, cout8}, 32'd0);
        check_eq({tag, "_ovf"}, {31'b0, ovf8}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_clear8("reset8");
        check_eq("reset1_busy", {31'b0, busy1}, 32'd0);
        check_eq("reset1_result", {31'b0, result1}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            @(posedge clk); #1;
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 1'b0; start1 = 1'b1;
            q1.push_back(model(1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0, cyc + 2));
            @(posedge clk); #1;
            start1 = 1'b0;
            repeat (2) @(posedge clk);
        end

        go8(8'h0F, 8'h01, 1'b0, 1'b0);
        go8(8'hFF, 8'h01, 1'b0, 1'b0);
        go8(8'h7F, 8'h01, 1'b0, 1'b0);
        go8(8'hA5, 8'h5A, 1'b1, 1'b0);
        go8(8'h05, 8'h07, 1'b0, 1'b1);
        go8(8'h80, 8'h01, 1'b0, 1'b1);
        go8(8'h10, 8'h01, 1'b1, 1'b1);

        // start held high: accepted from IDLE, then again in every DONE cycle.
        @(posedge clk); #1;
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 9 == 0) q8.push_back(model(8, 8'h3C, 8'h5A, 1'b1, 1'b0, cyc + 9));
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        repeat (12) @(posedge clk);

        // Reset in the 4th RUN cycle aborts without a done.
        @(posedge clk); #1;
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_outputs_clear8("abort");
        repeat (12) @(posedge clk);
        go8(8'h0F, 8'h01, 1'b0, 1'b0);

        // Reset and start together: reset wins, unit stays idle.
        @(posedge clk); #1;
        reset = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(posedge clk); #1;
        reset = 1'b0; start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("rst_start_busy", {31'b0, busy8}, 32'd0);
        end
        repeat (10) @(posedge clk);

        check_eq("q8_drained", q8.size(), 32'd0);
        check_eq("q1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
